lsu_byte_bridge: RTL
====================

Name: lsu_byte_bridge

Overview:
- Memory-side responder for the RV32I datapath's load/store requests (address, mem_size, mem_extend, store data).
- Serialises each 8/16/32-bit access into single-byte transactions on a byte-wide synchronous SRAM port, little-endian.
- Returns sign- or zero-extended load data with a one-cycle response pulse.
- Sits between the CU/datapath memory request signals and data memory.

Parameters:
- ADDR_W, 16, width of the byte-wide memory address bus; request address bits above ADDR_W-1 are ignored.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_extend  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- req_wdata  in  32  store data; low bytes used for sub-word stores
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_err  out  1  valid with rsp_valid: misaligned or illegal size
- rsp_rdata  out  32  extended load data, valid with rsp_valid; 0 for stores and errors
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid one cycle after a read strobe

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, byte index=0.
- Reset during an access abandons it. Bytes already written stay written. No response is issued.
- States: IDLE, ACCESS, TAIL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and clear the read-data buffer.
  - Error check: req_size=11, half with addr[0]=1, or word with addr[1:0]!=0 is an error. On error, go to RESP with rsp_err=1 and make no memory access.
  - Otherwise set N = 1, 2 or 4 and go to ACCESS.
- ACCESS (N cycles, index i = 0..N-1):
  - mem_en=1, mem_we=req_we, mem_addr = addr[ADDR_W-1:0] + i (modulo 2^ADDR_W).
  - mem_wdata = wdata[8i+7:8i].
  - For loads, mem_rdata is captured into buffer byte i-1 in the cycle after each strobe.
  - After i=N-1: loads go to TAIL, stores go to RESP.
- TAIL (loads only): mem_en=0; capture the last byte into buffer byte N-1; go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; mem_en=0; go to IDLE.
  - req_ready stays 0 in this cycle, so the next request is accepted no earlier than the following cycle.
- Extension, applied combinationally in RESP from the buffer:
  - 000: sign-extend byte 0.
  - 001: sign-extend bytes 1:0.
  - 100: zero-extend byte 0.
  - 101: zero-extend bytes 1:0.
  - 010, or any other code with size=10: full word.
  - Any other code: zero-extend the bytes selected by req_size.
- Latency from the accept edge to rsp_valid: load N+2 cycles (LB 3, LH 4, LW 6); store N+1 cycles (SB 2, SH 3, SW 5); error 1 cycle.
- req_valid and all request fields are ignored outside IDLE; the latched copy is used.
- No response backpressure: rsp_valid is a pulse and the consumer must sample it.
- mem_we is 0 whenever mem_en is 0.

Test Plan:
- Reset: assert rst_n=0 mid-SW after 2 bytes are written -> immediately req_ready=1, mem_en=0, rsp_valid=0. Memory holds bytes 0,1 of the new word and the old bytes 2,3.
- SW addr=0x100, wdata=0xDEADBEEF, then LW 0x100 -> strobes to 0x100..0x103 with bytes EF,BE,AD,DE. Store rsp_valid 5 cycles after accept. Load rsp_rdata=0xDEADBEEF 6 cycles after accept, rsp_err=0.
- Memory 0x200=0x80, 0x201=0xFF:
  - LB 0x200 -> 0xFFFFFF80.
  - LBU 0x200 -> 0x00000080.
  - LH 0x200 -> 0xFFFFFF80.
  - LHU 0x200 -> 0x0000FF80.
- SH addr=0x302, wdata=0x12345678 -> exactly two strobes: 0x302<-0x78, 0x303<-0x56. Neighbouring bytes unchanged.
- Misaligned LW addr=0x101 and SH addr=0x301 -> no mem_en. rsp_valid with rsp_err=1 and rsp_rdata=0 one cycle after accept. Memory unchanged.
- Back-to-back: req_valid held high with LB then SB -> second accept occurs in the cycle after the first rsp_valid; req_ready=0 throughout each access.

Source files
------------

// File: rtl/lsu_byte_bridge.sv
// Byte-serialising load/store responder: splits 8/16/32-bit RV32I accesses into
// little-endian single-byte SRAM transactions and returns extended load data.
//
// state  | meaning
// IDLE   | ready for a request; latch it and check alignment
// ACCESS | one memory strobe per cycle, byte index 0..N-1
// TAIL   | loads only: capture the final read byte
// RESP   | one-cycle response pulse
module lsu_byte_bridge #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic [2:0]        req_extend,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TAIL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [2:0]        ext_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [1:0]        idx;
    logic [1:0]        last_idx;
    logic [31:0]       rbuf;
    logic [1:0]        cap_idx;
    logic              req_err;
    logic [31:0]       ext_data;
    logic              addr_unused;

    assign addr_unused = ^req_addr[31:ADDR_W];

    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));

    // Read data lags its strobe by one cycle, so capture targets the previous index.
    assign cap_idx = idx - 2'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (req_valid) state_nxt = req_err ? RESP : ACCESS;
            ACCESS: if (idx == last_idx) state_nxt = we_q ? RESP : TAIL;
            TAIL:   state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            ext_q    <= 3'b000;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            idx      <= 2'd0;
            last_idx <= 2'd0;
            rbuf     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr[ADDR_W-1:0];
                        size_q  <= req_size;
                        ext_q   <= req_extend;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        idx     <= 2'd0;
                        rbuf    <= '0;
                        case (req_size)
                            2'b01:   last_idx <= 2'd1;
                            2'b10:   last_idx <= 2'd3;
                            default: last_idx <= 2'd0;
                        endcase
                    end
                end
                ACCESS: begin
                    if (!we_q && (idx != 2'd0))
                        rbuf[{cap_idx, 3'b000} +: 8] <= mem_rdata;
                    idx <= idx + 2'd1;
                end
                TAIL: rbuf[{last_idx, 3'b000} +: 8] <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        ext_data = '0;
        case (ext_q)
            3'b000: ext_data = {{24{rbuf[7]}}, rbuf[7:0]};
            3'b001: ext_data = {{16{rbuf[15]}}, rbuf[15:0]};
            3'b100: ext_data = {24'h0, rbuf[7:0]};
            3'b101: ext_data = {16'h0, rbuf[15:0]};
            default: begin
                case (size_q)
                    2'b10:   ext_data = rbuf;
                    2'b01:   ext_data = {16'h0, rbuf[15:0]};
                    default: ext_data = {24'h0, rbuf[7:0]};
                endcase
            end
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) & err_q;
    assign rsp_rdata = ((state == RESP) && !err_q && !we_q) ? ext_data : 32'h0;

    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? (addr_q + ADDR_W'(idx)) : '0;
    assign mem_wdata = mem_en ? wdata_q[{idx, 3'b000} +: 8] : 8'h00;

endmodule
